// File: rtl/nanocache_assoc_wb_pkg.sv
// Shared types and geometry helpers for the fully associative write-back nano cache.
package nanocache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_REFILL_REQ,
        ST_REFILL_WAIT,
        ST_RESP,
        ST_FLUSH_SCAN,
        ST_FLUSH_WB
    } cache_state_e;

    localparam int unsigned DEF_NUM_LINES  = 4;
    localparam int unsigned DEF_LINE_WORDS = 8;

    function automatic int unsigned off_bits(int unsigned line_words);
        return $clog2(line_words * 4);
    endfunction

    function automatic int unsigned tag_bits(int unsigned line_words);
        return 32 - off_bits(line_words);
    endfunction

    // Line record at the default geometry; the top re-declares it at its own sizes.
    typedef struct packed {
        logic                            valid;
        logic                            dirty;
        logic [31-$clog2(DEF_LINE_WORDS*4):0] tag;
        logic [DEF_LINE_WORDS*32-1:0]    data;
    } cache_line_t;

endpackage

// File: rtl/nanocache_assoc_wb_if.sv
// PE-side data/flush bundle and SRAM-side line bundle of the nano cache.
interface nanocache_data_if;
    logic        i_flush;
    logic        o_flush_done;
    logic        o_data_gnt;
    logic        i_data_req;
    logic        i_data_we;
    logic [31:0] i_data_addr;
    logic [3:0]  i_data_wstrb;
    logic [31:0] i_data_wdata;
    logic        o_data_valid;
    logic [31:0] o_data_rdata;

    modport master (
        output i_flush, i_data_req, i_data_we, i_data_addr, i_data_wstrb, i_data_wdata,
        input  o_flush_done, o_data_gnt, o_data_valid, o_data_rdata
    );
    modport slave (
        input  i_flush, i_data_req, i_data_we, i_data_addr, i_data_wstrb, i_data_wdata,
        output o_flush_done, o_data_gnt, o_data_valid, o_data_rdata
    );
endinterface

interface nanocache_mm_if #(parameter int unsigned LINE_WORDS = 8);
    logic                       o_mm_rden;
    logic                       o_mm_wren;
    logic [31:0]                o_mm_addr;
    logic [LINE_WORDS*32-1:0]   o_mm_wdata;
    logic [LINE_WORDS*4-1:0]    o_mm_wstrb;
    logic                       i_mm_gnt;
    logic [LINE_WORDS*32-1:0]   i_mm_rdata;
    logic                       i_mm_rvalid;

    modport master (
        output o_mm_rden, o_mm_wren, o_mm_addr, o_mm_wdata, o_mm_wstrb,
        input  i_mm_gnt, i_mm_rdata, i_mm_rvalid
    );
    modport slave (
        input  o_mm_rden, o_mm_wren, o_mm_addr, o_mm_wdata, o_mm_wstrb,
        output i_mm_gnt, i_mm_rdata, i_mm_rvalid
    );
endinterface

// File: rtl/nanocache_assoc_wb_victim_sel.sv
// Victim choice: lowest-index invalid line, otherwise the round-robin pointer.
module nanocache_victim_sel #(
    parameter int unsigned NUM_LINES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         advance,
    input  logic [NUM_LINES-1:0]         valid,
    output logic [$clog2(NUM_LINES)-1:0] victim
);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);

    logic [IDX_W-1:0] rr_ptr;
    logic             found;

    // Power-of-two line count lets the pointer wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= rr_ptr + 1'b1;
        end
    end

    always_comb begin
        victim = rr_ptr;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            if (!valid[i] && !found) begin
                victim = IDX_W'(i);
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/nanocache_assoc_wb.sv
// Fully associative write-back data cache between a PE data port and an SRAM line port.
module nanocache_assoc_wb
    import nanocache_pkg::*;
#(
    parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic              i_clk,
    input  logic              i_rst,
    nanocache_data_if.slave   data,
    nanocache_mm_if.master    mm
);
    localparam int unsigned OFF       = off_bits(LINE_WORDS);
    localparam int unsigned TAG_W     = tag_bits(LINE_WORDS);
    localparam int unsigned WORD_W    = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W     = $clog2(NUM_LINES);
    localparam int unsigned LINE_BITS = LINE_WORDS * 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_W-1:0]     tag;
        logic [LINE_BITS-1:0] data;
    } line_t;

    line_t            lines [NUM_LINES];
    cache_state_e     state, state_nx;
    logic             flush_pend, req_pend, req_we;
    logic [TAG_W-1:0] req_tag;
    logic [WORD_W-1:0] req_word;
    logic [3:0]       req_wstrb;
    logic [31:0]      req_wdata, rdata_q;
    logic [IDX_W-1:0] victim_q, victim_idx, scan_idx, hit_idx;
    logic             victim_was_valid, flush_done_q;
    logic [NUM_LINES-1:0] valid_vec;
    logic             hit, gnt, take_flush, flush_finish, advance;
    logic             unused_addr_lsb;

    assign unused_addr_lsb = ^data.i_data_addr[1:0];

    function automatic logic [31:0] get_word(logic [LINE_BITS-1:0] d, logic [WORD_W-1:0] w);
        return d[int'(w)*32 +: 32];
    endfunction

    function automatic logic [LINE_BITS-1:0] merge(logic [LINE_BITS-1:0] d, logic [WORD_W-1:0] w,
                                                   logic [3:0] strb, logic [31:0] wd);
        logic [LINE_BITS-1:0] r;
        r = d;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) r[int'(w)*32 + int'(b)*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            valid_vec[i] = lines[i].valid;
            if (lines[i].valid && lines[i].tag == req_tag) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    nanocache_victim_sel #(.NUM_LINES(NUM_LINES)) u_victim (
        .clk     (i_clk),
        .rst     (i_rst),
        .clear   (take_flush),
        .advance (advance),
        .valid   (valid_vec),
        .victim  (victim_idx)
    );

    always_comb begin
        state_nx      = state;
        gnt           = 1'b0;
        take_flush    = 1'b0;
        flush_finish  = 1'b0;
        advance       = 1'b0;
        mm.o_mm_rden  = 1'b0;
        mm.o_mm_wren  = 1'b0;
        mm.o_mm_addr  = '0;
        mm.o_mm_wdata = '0;
        mm.o_mm_wstrb = '0;
        data.o_data_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_pend) begin
                    if (hit) state_nx = ST_RESP;
                    else if (lines[victim_idx].valid && lines[victim_idx].dirty) state_nx = ST_WB;
                    else state_nx = ST_REFILL_REQ;
                end else if (flush_pend || data.i_flush) begin
                    take_flush = 1'b1;
                    state_nx   = ST_FLUSH_SCAN;
                end else begin
                    gnt = !i_rst;
                end
            end
            ST_WB: begin
                mm.o_mm_wren  = 1'b1;
                mm.o_mm_addr  = {lines[victim_q].tag, {OFF{1'b0}}};
                mm.o_mm_wdata = lines[victim_q].data;
                mm.o_mm_wstrb = '1;
                if (mm.i_mm_gnt) state_nx = ST_REFILL_REQ;
            end
            ST_REFILL_REQ: begin
                mm.o_mm_rden = 1'b1;
                mm.o_mm_addr = {req_tag, {OFF{1'b0}}};
                if (mm.i_mm_gnt) state_nx = ST_REFILL_WAIT;
            end
            ST_REFILL_WAIT: begin
                if (mm.i_mm_rvalid) begin
                    advance  = victim_was_valid;
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                data.o_data_valid = 1'b1;
                state_nx = ST_IDLE;
            end
            ST_FLUSH_SCAN: begin
                if (lines[scan_idx].valid && lines[scan_idx].dirty) begin
                    state_nx = ST_FLUSH_WB;
                end else if (scan_idx == LAST_IDX) begin
                    flush_finish = 1'b1;
                    state_nx     = ST_IDLE;
                end
            end
            ST_FLUSH_WB: begin
                mm.o_mm_wren  = 1'b1;
                mm.o_mm_addr  = {lines[scan_idx].tag, {OFF{1'b0}}};
                mm.o_mm_wdata = lines[scan_idx].data;
                mm.o_mm_wstrb = '1;
                if (mm.i_mm_gnt) begin
                    flush_finish = (scan_idx == LAST_IDX);
                    state_nx     = (scan_idx == LAST_IDX) ? ST_IDLE : ST_FLUSH_SCAN;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign data.o_data_gnt   = gnt;
    assign data.o_data_rdata = rdata_q;
    assign data.o_flush_done = flush_done_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= ST_IDLE;
            flush_pend       <= 1'b0;
            req_pend         <= 1'b0;
            req_we           <= 1'b0;
            req_tag          <= '0;
            req_word         <= '0;
            req_wstrb        <= '0;
            req_wdata        <= '0;
            rdata_q          <= '0;
            victim_q         <= '0;
            victim_was_valid <= 1'b0;
            scan_idx         <= '0;
            flush_done_q     <= 1'b0;
            for (int unsigned i = 0; i < NUM_LINES; i++) lines[i] <= '0;
        end else begin
            state        <= state_nx;
            flush_done_q <= flush_finish;
            flush_pend   <= (flush_pend | data.i_flush) & ~take_flush;
            if (gnt && data.i_data_req) begin
                req_pend  <= 1'b1;
                req_we    <= data.i_data_we;
                req_tag   <= data.i_data_addr[31:OFF];
                req_word  <= data.i_data_addr[OFF-1:2];
                req_wstrb <= data.i_data_wstrb;
                req_wdata <= data.i_data_wdata;
            end
            case (state)
                ST_IDLE: begin
                    if (req_pend && hit) begin
                        req_pend <= 1'b0;
                        if (req_we) begin
                            lines[hit_idx].data  <= merge(lines[hit_idx].data, req_word, req_wstrb, req_wdata);
                            lines[hit_idx].dirty <= 1'b1;
                        end else begin
                            rdata_q <= get_word(lines[hit_idx].data, req_word);
                        end
                    end else if (req_pend) begin
                        victim_q         <= victim_idx;
                        victim_was_valid <= lines[victim_idx].valid;
                    end else if (take_flush) begin
                        scan_idx <= '0;
                    end
                end
                ST_WB: if (mm.i_mm_gnt) lines[victim_q].dirty <= 1'b0;
                ST_REFILL_WAIT: begin
                    if (mm.i_mm_rvalid) begin
                        req_pend              <= 1'b0;
                        lines[victim_q].valid <= 1'b1;
                        lines[victim_q].dirty <= req_we;
                        lines[victim_q].tag   <= req_tag;
                        lines[victim_q].data  <= req_we ? merge(mm.i_mm_rdata, req_word, req_wstrb, req_wdata)
                                                        : mm.i_mm_rdata;
                        if (!req_we) rdata_q <= get_word(mm.i_mm_rdata, req_word);
                    end
                end
                ST_FLUSH_SCAN: begin
                    if (!(lines[scan_idx].valid && lines[scan_idx].dirty) && scan_idx != LAST_IDX)
                        scan_idx <= scan_idx + 1'b1;
                end
                ST_FLUSH_WB: begin
                    if (mm.i_mm_gnt) begin
                        lines[scan_idx].dirty <= 1'b0;
                        if (scan_idx != LAST_IDX) scan_idx <= scan_idx + 1'b1;
                    end
                end
                default: ;
            endcase
            if (flush_finish) begin
                for (int unsigned i = 0; i < NUM_LINES; i++) begin
                    lines[i].valid <= 1'b0;
                    lines[i].dirty <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_nanocache_assoc_wb.sv
// Directed bench for nanocache_assoc_wb with a behavioural line memory responder.
module tb_nanocache_assoc_wb;
    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_err;

    nanocache_data_if d();
    nanocache_mm_if #(.LINE_WORDS(8)) m();

    nanocache_assoc_wb #(.NUM_LINES(4), .LINE_WORDS(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .data  (d),
        .mm    (m)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0]  mem [1024];
    logic [31:0]  log_addr [$];
    logic         log_wr   [$];
    logic [255:0] log_data [$];
    int           gnt_dly;
    logic         hold_rvalid;
    int           inject_req;
    int           rv_cyc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[w*32 +: 32] = mem[int'(a[11:5])*8 + w];
        return r;
    endfunction

    // Memory responder: grant after gnt_dly waiting cycles, refill one cycle after grant.
    initial begin
        int          wait_cnt;
        int          inject_seen;
        logic        rv_pend;
        logic [31:0] rv_addr, first_addr;
        wait_cnt = 0; inject_seen = 0; rv_pend = 1'b0; rv_addr = '0; first_addr = '0;
        m.i_mm_gnt = 1'b0; m.i_mm_rvalid = 1'b0; m.i_mm_rdata = '0;
        forever begin
            @(negedge clk);
            m.i_mm_gnt = 1'b0; m.i_mm_rvalid = 1'b0; m.i_mm_rdata = '0;
            if (inject_req != inject_seen) begin
                inject_seen   = inject_req;
                m.i_mm_rvalid = 1'b1;
                m.i_mm_rdata  = {8{32'hBAD0BAD0}};
            end
            if (rst) begin
                wait_cnt = 0; rv_pend = 1'b0;
            end else begin
                if (rv_pend) begin
                    rv_pend = 1'b0;
                    if (!hold_rvalid) begin
                        m.i_mm_rvalid = 1'b1;
                        m.i_mm_rdata  = line_of(rv_addr);
                        rv_cyc        = cyc;
                    end
                end
                if (m.o_mm_rden || m.o_mm_wren) begin
                    if (wait_cnt == 0) first_addr = m.o_mm_addr;
                    if (wait_cnt == gnt_dly) begin
                        m.i_mm_gnt = 1'b1;
                        check_eq("mm_addr_stable", m.o_mm_addr, first_addr);
                        check_eq("mm_rd_wr_excl", m.o_mm_rden & m.o_mm_wren, 0);
                        log_addr.push_back(m.o_mm_addr);
                        log_wr.push_back(m.o_mm_wren);
                        log_data.push_back(m.o_mm_wdata);
                        if (m.o_mm_wren) begin
                            check_eq("mm_wstrb", m.o_mm_wstrb, 32'hFFFF_FFFF);
                            for (int w = 0; w < 8; w++)
                                mem[int'(m.o_mm_addr[11:5])*8 + w] = m.o_mm_wdata[w*32 +: 32];
                        end else begin
                            rv_pend = 1'b1;
                            rv_addr = m.o_mm_addr;
                        end
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    end

    task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat);
        int budget;
        @(negedge clk);
        d.i_data_req = 1'b1; d.i_data_we = we; d.i_data_addr = addr;
        d.i_data_wstrb = strb; d.i_data_wdata = wd;
        budget = 0;
        #1;
        while (!d.o_data_gnt && budget < 200) begin
            @(negedge clk); #1; budget++;
        end
        if (!d.o_data_gnt) begin
            check_eq("gnt_timeout", 0, 1);
            d.i_data_req = 1'b0; rd = '0; lat = -1;
            return;
        end
        @(negedge clk);
        d.i_data_req = 1'b0;
        lat = 1;
        while (!d.o_data_valid && lat < 300) begin
            @(negedge clk); lat++;
        end
        if (!d.o_data_valid) check_eq("valid_timeout", 0, 1);
        rd = d.o_data_rdata;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                              input int exp_logs);
        logic [31:0] rd;
        int lat, base;
        base = log_addr.size();
        access(1'b0, addr, 4'h0, 32'h0, rd, lat);
        check_eq({tag, "_data"}, rd, exp);
        check_eq({tag, "_mmops"}, log_addr.size() - base, exp_logs);
    endtask

    task automatic check_log(input string tag, input int idx, input logic wr, input logic [31:0] addr);
        if (idx >= log_addr.size()) begin
            check_eq({tag, "_present"}, log_addr.size(), idx + 1);
        end else begin
            check_eq({tag, "_kind"}, log_wr[idx], wr);
            check_eq({tag, "_addr"}, log_addr[idx], addr);
        end
    endtask

    task automatic wait_flush_done(input string tag);
        int budget;
        budget = 0;
        while (!d.o_flush_done && budget < 200) begin
            @(negedge clk); budget++;
        end
        check_eq({tag, "_done"}, d.o_flush_done, 1);
    endtask

    initial begin
        logic [31:0] rd;
        int lat, base;
        n_vec = 0; n_err = 0; cyc = 0; rv_cyc = 0;
        gnt_dly = 0; hold_rvalid = 1'b0; inject_req = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i * 4;
        mem[32'h108 >> 2] = 32'h0000_A5A5;
        rst = 1'b1;
        d.i_flush = 1'b0; d.i_data_req = 1'b0; d.i_data_we = 1'b0;
        d.i_data_addr = '0; d.i_data_wstrb = '0; d.i_data_wdata = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_gnt", d.o_data_gnt, 0);
        check_eq("rst_valid", d.o_data_valid, 0);
        check_eq("rst_rdata", d.o_data_rdata, 0);
        check_eq("rst_flush_done", d.o_flush_done, 0);
        check_eq("rst_mm_en", {m.o_mm_rden, m.o_mm_wren}, 0);
        check_eq("rst_mm_bus", {m.o_mm_addr, m.o_mm_wstrb}, 0);
        rst = 1'b0;

        // Cold read: one refill of 0x100, response one cycle after rvalid.
        access(1'b0, 32'h108, 4'h0, 32'h0, rd, lat);
        check_eq("cold_data", rd, 32'h0000_A5A5);
        check_eq("cold_resp_cycle", cyc, rv_cyc + 1);
        check_log("cold_rd", 0, 1'b0, 32'h100);

        // Hit: valid at N+2, grant back at N+3, no memory traffic.
        base = log_addr.size();
        access(1'b0, 32'h104, 4'h0, 32'h0, rd, lat);
        check_eq("hit_data", rd, 32'h1000_0104);
        check_eq("hit_latency", lat, 2);
        check_eq("hit_no_gnt_in_resp", d.o_data_gnt, 0);
        @(negedge clk); #1;
        check_eq("hit_regrant", d.o_data_gnt, 1);
        check_eq("hit_mmops", log_addr.size() - base, 0);

        access(1'b1, 32'h104, 4'b0011, 32'h0000_1234, rd, lat);
        check_eq("wr_hit_latency", lat, 2);
        read_check("merge", 32'h104, 32'h1000_1234, 0);

        // Fill the three invalid lines, then evict line 0 (dirty) and line 1 (clean).
        read_check("fill0", 32'h000, 32'h1000_0000, 1);
        read_check("fill1", 32'h024, 32'h1000_0024, 1);
        read_check("fill2", 32'h048, 32'h1000_0048, 1);
        base = log_addr.size();
        read_check("evict0", 32'h080, 32'h1000_0080, 2);
        check_log("evict0_wb", base, 1'b1, 32'h100);
        check_log("evict0_rd", base + 1, 1'b0, 32'h080);
        if (base < log_data.size()) check_eq("evict0_wb_word", log_data[base][63:32], 32'h1000_1234);
        read_check("evict1", 32'h0A0, 32'h1000_00A0, 1);
        read_check("keep2", 32'h020, 32'h1000_0020, 0);
        read_check("keep3", 32'h040, 32'h1000_0040, 0);
        read_check("evict_old1", 32'h000, 32'h1000_0000, 1);

        // Two dirty lines (indices 1 and 3), flushed with a slow memory grant.
        access(1'b1, 32'h0A4, 4'hF, 32'hDEAD_BEEF, rd, lat);
        access(1'b1, 32'h044, 4'b1100, 32'h55AA_9999, rd, lat);
        gnt_dly = 2;
        base = log_addr.size();
        @(negedge clk); d.i_flush = 1'b1;
        @(negedge clk); d.i_flush = 1'b0;
        wait_flush_done("flush");
        check_eq("flush_wb_count", log_addr.size() - base, 2);
        check_log("flush_wb0", base, 1'b1, 32'h0A0);
        check_log("flush_wb1", base + 1, 1'b1, 32'h040);
        if (base + 1 < log_data.size()) begin
            check_eq("flush_wb0_word", log_data[base][63:32], 32'hDEAD_BEEF);
            check_eq("flush_wb1_word", log_data[base + 1][63:32], 32'h55AA_0044);
        end
        gnt_dly = 0;
        read_check("post_flush_a", 32'h0A4, 32'hDEAD_BEEF, 1);
        read_check("post_flush_b", 32'h104, 32'h1000_1234, 1);

        // Flush and request together: flush wins, request granted afterwards.
        base = log_addr.size();
        @(negedge clk);
        d.i_flush = 1'b1; d.i_data_req = 1'b1; d.i_data_we = 1'b0; d.i_data_addr = 32'h0A8;
        #1;
        check_eq("flush_beats_req", d.o_data_gnt, 0);
        @(negedge clk); d.i_flush = 1'b0;
        wait_flush_done("flush2");
        #1;
        check_eq("req_after_flush_gnt", d.o_data_gnt, 1);
        @(negedge clk); d.i_data_req = 1'b0;
        lat = 1;
        while (!d.o_data_valid && lat < 300) begin
            @(negedge clk); lat++;
        end
        check_eq("req_after_flush_data", {d.o_data_valid, d.o_data_rdata}, {1'b1, 32'h1000_00A8});
        check_eq("flush2_mmops", log_addr.size() - base, 1);
        check_log("flush2_rd", base, 1'b0, 32'h0A0);

        // Reset while waiting for refill; a late rvalid must be ignored.
        hold_rvalid = 1'b1;
        base = log_addr.size();
        @(negedge clk);
        d.i_data_req = 1'b1; d.i_data_addr = 32'h300;
        @(negedge clk); d.i_data_req = 1'b0;
        lat = 0;
        while (log_addr.size() == base && lat < 50) begin
            @(negedge clk); lat++;
        end
        check_eq("rstmid_rd_issued", log_addr.size() - base, 1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check_eq("rstmid_outputs",
                 {d.o_data_gnt, d.o_data_valid, d.o_flush_done, m.o_mm_rden, m.o_mm_wren, d.o_data_rdata}, 0);
        rst = 1'b0;
        hold_rvalid = 1'b0;
        inject_req++;
        repeat (3) begin
            @(negedge clk);
            check_eq("late_rvalid_no_resp", d.o_data_valid, 0);
        end
        read_check("after_rstmid", 32'h300, 32'h1000_0300, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
